// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared constants, state codes and pixel distance helper for the bullet wave scheduler
package bullet_pkg;

  localparam int COORD_W = 10;

  localparam logic [COORD_W-1:0] H_LAST = 10'd639;
  localparam logic [COORD_W-1:0] V_LAST = 10'd479;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Squared euclidean distance between a pixel and a bullet centre, done on magnitudes.
  function automatic logic [2*COORD_W+1:0] dist_sq(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy
  );
    logic [COORD_W:0]       dx, dy, ax, ay;
    logic [2*COORD_W+1:0]   wx, wy;
    dx = {1'b0, px} - {1'b0, cx};
    dy = {1'b0, py} - {1'b0, cy};
    ax = dx[COORD_W] ? -dx : dx;
    ay = dy[COORD_W] ? -dy : dy;
    wx = {{(COORD_W+1){1'b0}}, ax};
    wy = {{(COORD_W+1){1'b0}}, ay};
    return wx * wx + wy * wy;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// rtl/bullet_slot.sv - one bullet slot: position, direction, lifetime, bounce and expiry
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int STEP     = 6,
  parameter int X_MIN    = 230,
  parameter int X_MAX    = 416,
  parameter int SPAWN_X  = 250,
  parameter int SPAWN_Y  = 320,
  parameter int LIFETIME = 60
) (
  input  logic               Pclk,
  input  logic               rst,
  input  logic               move,
  input  logic               spawn,
  input  logic               spawn_dir,
  input  logic               clear,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active
);

  localparam int LIFE_W = $clog2(LIFETIME + 1);

  localparam logic [COORD_W:0]   STEP_W    = STEP[COORD_W:0];
  localparam logic [COORD_W:0]   XMIN_W    = X_MIN[COORD_W:0];
  localparam logic [COORD_W:0]   XMAX_W    = X_MAX[COORD_W:0];
  localparam logic [COORD_W-1:0] SPAWN_X_W = SPAWN_X[COORD_W-1:0];
  localparam logic [COORD_W-1:0] SPAWN_Y_W = SPAWN_Y[COORD_W-1:0];
  localparam logic [LIFE_W-1:0]  LIFE_INIT = LIFETIME[LIFE_W-1:0];
  localparam logic [LIFE_W-1:0]  LIFE_ONE  = LIFE_W'(1);

  logic              dir;
  logic [LIFE_W-1:0] life;
  logic [COORD_W:0]  x_ext;

  // One extra bit so x+STEP cannot wrap before the limit compare.
  assign x_ext = {1'b0, x};

  always_ff @(posedge Pclk) begin
    if (rst) begin
      x      <= SPAWN_X_W;
      y      <= SPAWN_Y_W;
      dir    <= DIR_RIGHT;
      life   <= '0;
      active <= 1'b0;
    end else if (clear && active) begin
      active <= 1'b0;
    end else if (spawn) begin
      x      <= SPAWN_X_W;
      y      <= SPAWN_Y_W;
      dir    <= spawn_dir;
      life   <= LIFE_INIT;
      active <= 1'b1;
    end else if (move && active) begin
      if (dir == DIR_RIGHT) begin
        if (x_ext + STEP_W > XMAX_W) begin
          x   <= XMAX_W[COORD_W-1:0];
          dir <= DIR_LEFT;
        end else begin
          x <= x + STEP_W[COORD_W-1:0];
        end
      end else begin
        if (x_ext < XMIN_W + STEP_W) begin
          x   <= XMIN_W[COORD_W-1:0];
          dir <= DIR_RIGHT;
        end else begin
          x <= x - STEP_W[COORD_W-1:0];
        end
      end
      life <= life - LIFE_ONE;
      if (life == LIFE_ONE) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bullet_wave_scheduler.sv
// rtl/bullet_wave_scheduler.sv - wave sequencer: spawn schedule, slot array, end-of-wave
// Optional pixel hit output enabled by defining BULLET_PIXEL_EN.
module bullet_wave_scheduler
  import bullet_pkg::*;
#(
  parameter int N_BULLETS  = 4,
  parameter int MOVE_DIV   = 3,
  parameter int STEP       = 6,
  parameter int X_MIN      = 230,
  parameter int X_MAX      = 416,
  parameter int SPAWN_X    = 250,
  parameter int SPAWN_Y    = 320,
  parameter int Y_PITCH    = 16,
  parameter int SPAWN_GAP  = 8,
  parameter int WAVE_COUNT = 8,
  parameter int LIFETIME   = 60,
  parameter int RADIUS     = 5
) (
  input  logic                         Pclk,
  input  logic                         rst,
  input  logic [COORD_W-1:0]           xx,
  input  logic [COORD_W-1:0]           yy,
  input  logic                         aactive,
  input  logic                         start,
  input  logic [N_BULLETS-1:0]         collision,
  output logic [COORD_W*N_BULLETS-1:0] bullet_x,
  output logic [COORD_W*N_BULLETS-1:0] bullet_y,
  output logic [N_BULLETS-1:0]         bullet_active,
  output logic                         busy,
  output logic                         wave_done,
  output logic                         bullet_on
);

  localparam int CNT_W = $clog2(WAVE_COUNT + 1);
  localparam int TMR_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int IDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  localparam int GAP_LAST_I = SPAWN_GAP - 1;
  localparam int DIV_LAST_I = MOVE_DIV - 1;

  localparam logic [CNT_W-1:0] WAVE_LAST = WAVE_COUNT[CNT_W-1:0];
  localparam logic [TMR_W-1:0] GAP_LAST  = GAP_LAST_I[TMR_W-1:0];
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_LAST_I[DIV_W-1:0];

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [TMR_W-1:0]   spawn_timer;
  logic [CNT_W-1:0]   spawned_cnt;

  logic               frame_tick;
  logic               move_tick;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               do_spawn;
  logic               spawn_dir;
  logic [N_BULLETS-1:0] spawn_vec;

  assign frame_tick = (xx == H_LAST) && (yy == V_LAST);
  assign move_tick  = (state == RUN) && frame_tick && (div_cnt == DIV_LAST);

  // Lowest free slot taken from the registered flags, so slots freed this edge wait a tick.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!bullet_active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign do_spawn  = move_tick && (spawn_timer == GAP_LAST) &&
                     (spawned_cnt < WAVE_LAST) && free_found;
  assign spawn_dir = spawned_cnt[0] ? DIR_LEFT : DIR_RIGHT;

  always_comb begin
    spawn_vec = '0;
    if (do_spawn) begin
      spawn_vec[free_idx] = 1'b1;
    end
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      spawn_timer <= '0;
      spawned_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            div_cnt     <= '0;
            spawned_cnt <= '0;
            spawn_timer <= GAP_LAST;
          end
        end
        RUN: begin
          if (frame_tick) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          end
          if (move_tick) begin
            if (do_spawn) begin
              spawn_timer <= '0;
              spawned_cnt <= spawned_cnt + 1'b1;
            end else if (spawn_timer != GAP_LAST) begin
              spawn_timer <= spawn_timer + 1'b1;
            end
          end
          if ((spawned_cnt == WAVE_LAST) && (bullet_active == '0)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign wave_done = (state == DONE);

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .STEP     (STEP),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX),
      .SPAWN_X  (SPAWN_X),
      .SPAWN_Y  (SPAWN_Y + i * Y_PITCH),
      .LIFETIME (LIFETIME)
    ) u_slot (
      .Pclk      (Pclk),
      .rst       (rst),
      .move      (move_tick),
      .spawn     (spawn_vec[i]),
      .spawn_dir (spawn_dir),
      .clear     (collision[i]),
      .x         (bullet_x[COORD_W*i +: COORD_W]),
      .y         (bullet_y[COORD_W*i +: COORD_W]),
      .active    (bullet_active[i])
    );
  end

`ifdef BULLET_PIXEL_EN
  localparam int                   R_SQ_I = RADIUS * RADIUS;
  localparam logic [2*COORD_W+1:0] R_SQ   = R_SQ_I[2*COORD_W+1:0];

  logic pix_hit;

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (bullet_active[i] &&
          (dist_sq(xx, yy, bullet_x[COORD_W*i +: COORD_W],
                   bullet_y[COORD_W*i +: COORD_W]) <= R_SQ)) begin
        pix_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Pclk) begin
    if (rst) begin
      bullet_on <= 1'b0;
    end else begin
      bullet_on <= aactive && pix_hit;
    end
  end
`else
  logic unused_pix;
  assign unused_pix = aactive & RADIUS[0];
  assign bullet_on  = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// tb/tb_bullet_wave_scheduler.sv - directed and randomized checks against a frame-level behavioural model
module tb_bullet_wave_scheduler;

  localparam int NB = 4, MOVE_DIV = 3, STEP = 6, X_MIN = 230, X_MAX = 416;
  localparam int SPAWN_X = 250, SPAWN_Y = 320, Y_PITCH = 16, SPAWN_GAP = 8;
  localparam int WAVE_COUNT = 8, LIFETIME = 60, RADIUS = 5;
`ifdef BULLET_PIXEL_EN
  localparam bit PIX = 1'b1;
`else
  localparam bit PIX = 1'b0;
`endif

  logic            Pclk = 1'b0;
  logic            rst = 1'b1;
  logic [9:0]      xx = '0, yy = '0;
  logic            aactive = 1'b0, start = 1'b0;
  logic [NB-1:0]   collision = '0;
  logic [10*NB-1:0] bullet_x, bullet_y;
  logic [NB-1:0]   bullet_active;
  logic            busy, wave_done, bullet_on;

  always #5 Pclk = ~Pclk;

  bullet_wave_scheduler #(
    .N_BULLETS(NB), .MOVE_DIV(MOVE_DIV), .STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX),
    .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y), .Y_PITCH(Y_PITCH), .SPAWN_GAP(SPAWN_GAP),
    .WAVE_COUNT(WAVE_COUNT), .LIFETIME(LIFETIME), .RADIUS(RADIUS)
  ) dut (
    .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive), .start(start),
    .collision(collision), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .busy(busy), .wave_done(wave_done), .bullet_on(bullet_on)
  );

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int wd_cnt = 0;
  int tick_n = 0;

  // Model: positions as plain ints, move ticks derived from frames counted since start.
  int m_x[NB], m_dir[NB], m_life[NB];
  bit m_act[NB];
  int m_state, m_frames, m_since, m_spawned;
  bit m_on;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sq(input int v);
    return v * v;
  endfunction

  task automatic model_step();
    bit old_act[NB];
    bit mt, to_done;
    int free_i;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_x[i] = SPAWN_X; m_dir[i] = 1; m_life[i] = 0; m_act[i] = 0;
      end
      m_state = 0; m_frames = 0; m_since = 0; m_spawned = 0; m_on = 0;
      return;
    end
    m_on = 0;
    if (PIX && aactive)
      for (int i = 0; i < NB; i++)
        if (m_act[i] && sq(int'(xx) - m_x[i]) + sq(int'(yy) - (SPAWN_Y + i * Y_PITCH)) <= RADIUS * RADIUS)
          m_on = 1;
    old_act = m_act;
    mt = 0;
    to_done = 0;
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_frames = 0; m_spawned = 0; m_since = SPAWN_GAP - 1;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end else begin
      to_done = (m_spawned == WAVE_COUNT);
      for (int i = 0; i < NB; i++) if (old_act[i]) to_done = 0;
      if (xx == 10'd639 && yy == 10'd479) begin
        m_frames++;
        mt = (m_frames % MOVE_DIV) == 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (!old_act[i]) continue;
      if (collision[i]) m_act[i] = 0;
      else if (mt) begin
        if (m_dir[i] == 1) begin
          if (m_x[i] + STEP > X_MAX) begin m_x[i] = X_MAX; m_dir[i] = 0; end
          else m_x[i] += STEP;
        end else begin
          if (m_x[i] - STEP < X_MIN) begin m_x[i] = X_MIN; m_dir[i] = 1; end
          else m_x[i] -= STEP;
        end
        m_life[i]--;
        if (m_life[i] == 0) m_act[i] = 0;
      end
    end
    if (mt) begin
      free_i = -1;
      for (int i = NB - 1; i >= 0; i--) if (!old_act[i]) free_i = i;
      if (m_since >= SPAWN_GAP - 1 && m_spawned < WAVE_COUNT && free_i >= 0) begin
        m_x[free_i] = SPAWN_X;
        m_dir[free_i] = (m_spawned % 2 == 0) ? 1 : 0;
        m_life[free_i] = LIFETIME;
        m_act[free_i] = 1;
        m_spawned++;
        m_since = 0;
      end else begin
        m_since++;
      end
    end
    if (to_done) m_state = 2;
  endtask

  always @(posedge Pclk) begin
    #2;
    if (chk_en) begin
      for (int i = 0; i < NB; i++) begin
        chk($sformatf("x%0d", i), int'(bullet_x[10*i +: 10]), m_x[i]);
        chk($sformatf("y%0d", i), int'(bullet_y[10*i +: 10]), SPAWN_Y + i * Y_PITCH);
        chk($sformatf("active%0d", i), int'(bullet_active[i]), int'(m_act[i]));
      end
      chk("busy", int'(busy), int'(m_state == 1));
      chk("wave_done", int'(wave_done), int'(m_state == 2));
      chk("bullet_on", int'(bullet_on), int'(m_on));
      if (wave_done) wd_cnt++;
    end
  end

  task automatic drive(input int vx, input int vy, input bit vs, input logic [NB-1:0] vc,
                       input bit va, input bit vr);
    @(negedge Pclk);
    xx = vx[9:0]; yy = vy[9:0]; start = vs; collision = vc; aactive = va; rst = vr;
    model_step();
    @(posedge Pclk);
    #3;
  endtask

  task automatic mtick(input logic [NB-1:0] col);
    repeat (2) begin
      drive(639, 479, 0, '0, 0, 0);
      drive(0, 0, 0, '0, 0, 0);
    end
    drive(639, 479, 0, col, 0, 0);
    tick_n++;
  endtask

  task automatic ticks_to(input int target);
    while (tick_n < target) mtick('0);
  endtask

  int vx, vy, s;
  bit vs, va, vr;
  logic [NB-1:0] vc;

  initial begin
    drive(0, 0, 0, '0, 0, 1);
    chk_en = 1'b1;
    drive(0, 0, 0, '0, 0, 1);
    chk("rst_active", int'(bullet_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_x0", int'(bullet_x[9:0]), 250);
    chk("rst_y3", int'(bullet_y[39:30]), 368);

    drive(0, 0, 1, '0, 0, 0);
    chk("start_busy", int'(busy), 1);
    ticks_to(1);
    chk("t1_active", int'(bullet_active), 4'b0001);
    chk("t1_x0", int'(bullet_x[9:0]), 250);
    chk("t1_y0", int'(bullet_y[9:0]), 320);

    drive(253, 324, 0, '0, 1, 0);
    chk("pix_in", int'(bullet_on), int'(PIX));
    drive(254, 324, 0, '0, 1, 0);
    chk("pix_out", int'(bullet_on), 0);
    drive(253, 324, 0, '0, 0, 0);
    chk("pix_blank", int'(bullet_on), 0);

    ticks_to(2);  chk("t2_x0", int'(bullet_x[9:0]), 256);
    ticks_to(9);  chk("t9_active", int'(bullet_active), 4'b0011);
                  chk("t9_x0", int'(bullet_x[9:0]), 298);
    ticks_to(10); chk("t10_x1", int'(bullet_x[19:10]), 244);
    ticks_to(17); chk("t17_active", int'(bullet_active), 4'b0111);
    ticks_to(25); chk("t25_active", int'(bullet_active), 4'b1111);
    ticks_to(28); chk("t28_x0", int'(bullet_x[9:0]), 412);
    ticks_to(29); chk("t29_x0", int'(bullet_x[9:0]), 416);
    ticks_to(30); chk("t30_x0", int'(bullet_x[9:0]), 410);
    ticks_to(33); chk("t33_x1", int'(bullet_x[19:10]), 350);
    mtick(4'b0010);
    chk("col_active", int'(bullet_active), 4'b1101);
    chk("col_x1", int'(bullet_x[19:10]), 350);
    mtick('0);
    chk("respawn_active", int'(bullet_active), 4'b1111);
    chk("respawn_x1", int'(bullet_x[19:10]), 250);

    for (int k = 0; k < 30; k++) begin
      mtick(4'b1111);
      if (k == 5) begin
        drive(0, 0, 1, '0, 0, 0);
        chk("start_in_run", int'(busy), 1);
      end
    end
    chk("wave_done_pulses", wd_cnt, 1);
    chk("end_busy", int'(busy), 0);

    for (int c = 0; c < 20000; c++) begin
      vr = (c >= 8000 && c < 8003) || ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 2) == 0) begin
        vx = 639; vy = 479;
      end else if ($urandom_range(0, 1) == 0) begin
        s = int'($urandom_range(0, NB - 1));
        vx = m_x[s] + int'($urandom_range(0, 14)) - 7;
        vy = SPAWN_Y + s * Y_PITCH + int'($urandom_range(0, 14)) - 7;
      end else begin
        vx = int'($urandom_range(0, 1023));
        vy = int'($urandom_range(0, 1023));
      end
      vs = ($urandom_range(0, 49) == 0);
      vc = ($urandom_range(0, 29) == 0) ? NB'($urandom) : '0;
      va = ($urandom_range(0, 3) != 0);
      drive(vx, vy, vs, vc, va, vr);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
